lc3_sequencer: RTL and testbench

LC3_SEQUENCER -- requirements
Module: lc3_sequencer

---
 rtl/lc3_sequencer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_lc3_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_sequencer.sv
// LC-3 control sequencer: Moore FSM driving datapath load enables, bus gates,
// mux selects and SRAM strobes, with a wait counter stretching each memory access.
module lc3_sequencer #(
  parameter int unsigned MEM_WAIT = 2,
  parameter bit          PAUSE_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       MARMUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  localparam logic [5:0] S_HALTED     = 6'd0;
  localparam logic [5:0] S_FETCH      = 6'd1;
  localparam logic [5:0] S_RD_IR      = 6'd2;
  localparam logic [5:0] S_LOAD_IR    = 6'd3;
  localparam logic [5:0] S_DECODE     = 6'd4;
  localparam logic [5:0] S_ADD_R      = 6'd5;
  localparam logic [5:0] S_ADD_I      = 6'd6;
  localparam logic [5:0] S_AND_R      = 6'd7;
  localparam logic [5:0] S_AND_I      = 6'd8;
  localparam logic [5:0] S_NOT        = 6'd9;
  localparam logic [5:0] S_ADDR_LDR   = 6'd10;
  localparam logic [5:0] S_ADDR_LD    = 6'd11;
  localparam logic [5:0] S_ADDR_LDI   = 6'd12;
  localparam logic [5:0] S_ADDR_STR   = 6'd13;
  localparam logic [5:0] S_ADDR_ST    = 6'd14;
  localparam logic [5:0] S_ADDR_STI   = 6'd15;
  localparam logic [5:0] S_RD_PTR_LDI = 6'd16;
  localparam logic [5:0] S_RD_PTR_STI = 6'd17;
  localparam logic [5:0] S_INDIR_LDI  = 6'd18;
  localparam logic [5:0] S_INDIR_STI  = 6'd19;
  localparam logic [5:0] S_RD_DATA    = 6'd20;
  localparam logic [5:0] S_WB         = 6'd21;
  localparam logic [5:0] S_STDATA     = 6'd22;
  localparam logic [5:0] S_WRITE      = 6'd23;
  localparam logic [5:0] S_LEA        = 6'd24;
  localparam logic [5:0] S_JSR_SAVE   = 6'd25;
  localparam logic [5:0] S_JSR_OFF    = 6'd26;
  localparam logic [5:0] S_JSR_BASE   = 6'd27;
  localparam logic [5:0] S_JMP        = 6'd28;
  localparam logic [5:0] S_BRCHK      = 6'd29;
  localparam logic [5:0] S_BRTAKE     = 6'd30;
  localparam logic [5:0] S_TRAP_VEC   = 6'd31;
  localparam logic [5:0] S_TRAP_SAVE  = 6'd32;
  localparam logic [5:0] S_TRAP_RD    = 6'd33;
  localparam logic [5:0] S_TRAP_JUMP  = 6'd34;
  localparam logic [5:0] S_PAUSE1     = 6'd35;
  localparam logic [5:0] S_PAUSE2     = 6'd36;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  logic [5:0] state;
  logic [5:0] next_state;
  logic [2:0] wait_cnt;
  logic       in_mem;
  logic       wait_done;

  assign wait_done = (wait_cnt == WAIT_LAST);

  always_comb begin
    in_mem = 1'b0;
    case (state)
      S_RD_IR, S_RD_PTR_LDI, S_RD_PTR_STI, S_RD_DATA, S_TRAP_RD, S_WRITE: in_mem = 1'b1;
      default: in_mem = 1'b0;
    endcase
  end

  // Counter runs only inside memory states and returns to zero on every exit,
  // so each access starts counting from zero on entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_HALTED;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= (in_mem && !wait_done) ? wait_cnt + 3'd1 : '0;
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_HALTED:     next_state = Run ? S_FETCH : S_HALTED;
      S_FETCH:      next_state = S_RD_IR;
      S_RD_IR:      next_state = wait_done ? S_LOAD_IR : S_RD_IR;
      S_LOAD_IR:    next_state = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          4'b0001: next_state = IR_5 ? S_ADD_I : S_ADD_R;
          4'b0101: next_state = IR_5 ? S_AND_I : S_AND_R;
          4'b1001: next_state = S_NOT;
          4'b0110: next_state = S_ADDR_LDR;
          4'b0010: next_state = S_ADDR_LD;
          4'b1010: next_state = S_ADDR_LDI;
          4'b0111: next_state = S_ADDR_STR;
          4'b0011: next_state = S_ADDR_ST;
          4'b1011: next_state = S_ADDR_STI;
          4'b1110: next_state = S_LEA;
          4'b0100: next_state = S_JSR_SAVE;
          4'b1100: next_state = S_JMP;
          4'b0000: next_state = S_BRCHK;
          4'b1111: next_state = S_TRAP_VEC;
          4'b1101: next_state = PAUSE_EN ? S_PAUSE1 : S_FETCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_ADDR_LDR, S_ADDR_LD:   next_state = S_RD_DATA;
      S_ADDR_LDI:   next_state = S_RD_PTR_LDI;
      S_ADDR_STI:   next_state = S_RD_PTR_STI;
      S_ADDR_STR, S_ADDR_ST:   next_state = S_STDATA;
      S_RD_PTR_LDI: next_state = wait_done ? S_INDIR_LDI : S_RD_PTR_LDI;
      S_RD_PTR_STI: next_state = wait_done ? S_INDIR_STI : S_RD_PTR_STI;
      S_INDIR_LDI:  next_state = S_RD_DATA;
      S_INDIR_STI:  next_state = S_STDATA;
      S_RD_DATA:    next_state = wait_done ? S_WB : S_RD_DATA;
      S_STDATA:     next_state = S_WRITE;
      S_WRITE:      next_state = wait_done ? S_FETCH : S_WRITE;
      S_JSR_SAVE:   next_state = IR_11 ? S_JSR_OFF : S_JSR_BASE;
      S_BRCHK:      next_state = BEN ? S_BRTAKE : S_FETCH;
      S_TRAP_VEC:   next_state = S_TRAP_SAVE;
      S_TRAP_SAVE:  next_state = S_TRAP_RD;
      S_TRAP_RD:    next_state = wait_done ? S_TRAP_JUMP : S_TRAP_RD;
      S_PAUSE1:     next_state = Continue ? S_PAUSE2 : S_PAUSE1;
      S_PAUSE2:     next_state = Continue ? S_PAUSE2 : S_FETCH;
      default:      next_state = S_FETCH;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    MARMUX     = 1'b0;
    ALUK       = 2'b00;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    case (state)
      S_HALTED, S_PAUSE1, S_PAUSE2: LD_LED = 1'b1;
      S_FETCH: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S_RD_IR, S_RD_PTR_LDI, S_RD_PTR_STI, S_RD_DATA, S_TRAP_RD: begin
        Mem_OE = 1'b1;
        LD_MDR = wait_done;
      end
      S_LOAD_IR: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_DECODE: LD_BEN = 1'b1;
      S_ADD_R, S_ADD_I, S_AND_R, S_AND_I: begin
        ALUK    = (state == S_AND_R || state == S_AND_I) ? 2'b01 : 2'b00;
        SR1MUX  = 1'b1;
        SR2MUX  = (state == S_ADD_I || state == S_AND_I);
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_NOT: begin
        ALUK    = 2'b10;
        SR1MUX  = 1'b1;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_ADDR_LDR, S_ADDR_STR: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        SR1MUX     = 1'b1;
      end
      S_ADDR_LD, S_ADDR_ST, S_ADDR_LDI, S_ADDR_STI: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        ADDR2MUX   = 2'b10;
      end
      S_INDIR_LDI, S_INDIR_STI: begin
        GateMDR = 1'b1;
        LD_MAR  = 1'b1;
      end
      S_WB: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_STDATA: begin
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_WRITE: Mem_WE = 1'b1;
      S_LEA: begin
        ADDR2MUX   = 2'b10;
        GateMARMUX = 1'b1;
        LD_REG     = 1'b1;
      end
      S_JSR_SAVE, S_TRAP_SAVE: begin
        DRMUX  = 1'b1;
        GatePC = 1'b1;
        LD_REG = 1'b1;
      end
      S_JSR_OFF: begin
        ADDR2MUX = 2'b11;
        PCMUX    = 2'b01;
        LD_PC    = 1'b1;
      end
      S_JSR_BASE: begin
        ADDR1MUX = 1'b1;
        SR1MUX   = 1'b1;
        PCMUX    = 2'b01;
        LD_PC    = 1'b1;
      end
      S_JMP: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        PCMUX   = 2'b10;
        LD_PC   = 1'b1;
      end
      S_BRTAKE: begin
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b01;
        LD_PC    = 1'b1;
      end
      S_TRAP_VEC: begin
        MARMUX     = 1'b1;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_TRAP_JUMP: begin
        GateMDR = 1'b1;
        PCMUX   = 2'b10;
        LD_PC   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_sequencer.sv
// Bench for lc3_sequencer: three configurations (MEM_WAIT 2/3, PAUSE_EN 1/0)
// checked cycle by cycle against per-instruction expected control-word sequences.
module tb_lc3_sequencer;

  localparam logic [24:0] B_LD_MAR = 25'd1 << 0;
  localparam logic [24:0] B_LD_MDR = 25'd1 << 1;
  localparam logic [24:0] B_LD_IR  = 25'd1 << 2;
  localparam logic [24:0] B_LD_BEN = 25'd1 << 3;
  localparam logic [24:0] B_LD_CC  = 25'd1 << 4;
  localparam logic [24:0] B_LD_REG = 25'd1 << 5;
  localparam logic [24:0] B_LD_PC  = 25'd1 << 6;
  localparam logic [24:0] B_LD_LED = 25'd1 << 7;
  localparam logic [24:0] B_GPC    = 25'd1 << 8;
  localparam logic [24:0] B_GMDR   = 25'd1 << 9;
  localparam logic [24:0] B_GALU   = 25'd1 << 10;
  localparam logic [24:0] B_GMM    = 25'd1 << 11;
  localparam logic [24:0] PC_ADD   = 25'd1 << 12;
  localparam logic [24:0] PC_BUS   = 25'd2 << 12;
  localparam logic [24:0] B_DR7    = 25'd1 << 14;
  localparam logic [24:0] B_SR1    = 25'd1 << 15;
  localparam logic [24:0] B_SR2    = 25'd1 << 16;
  localparam logic [24:0] B_A1     = 25'd1 << 17;
  localparam logic [24:0] A2_OFF6  = 25'd1 << 18;
  localparam logic [24:0] A2_OFF9  = 25'd2 << 18;
  localparam logic [24:0] A2_OFF11 = 25'd3 << 18;
  localparam logic [24:0] B_MARZ   = 25'd1 << 20;
  localparam logic [24:0] ALU_AND  = 25'd1 << 21;
  localparam logic [24:0] ALU_NOT  = 25'd2 << 21;
  localparam logic [24:0] ALU_PASS = 25'd3 << 21;
  localparam logic [24:0] B_OE     = 25'd1 << 23;
  localparam logic [24:0] B_WE     = 25'd1 << 24;
  localparam logic [24:0] GATES    = B_GPC | B_GMDR | B_GALU | B_GMM;
  localparam logic [24:0] W_FETCH  = B_GPC | B_LD_MAR | B_LD_PC;
  localparam logic [24:0] W_LED    = B_LD_LED;

  typedef struct packed {
    logic [24:0] exp;
    logic        cont;
  } entry_t;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic [24:0] outs [3];

  entry_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lc3_sequencer #(
      .MEM_WAIT((g == 1) ? 3 : 2),
      .PAUSE_EN((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(outs[g][0]), .LD_MDR(outs[g][1]), .LD_IR(outs[g][2]), .LD_BEN(outs[g][3]),
      .LD_CC(outs[g][4]), .LD_REG(outs[g][5]), .LD_PC(outs[g][6]), .LD_LED(outs[g][7]),
      .GatePC(outs[g][8]), .GateMDR(outs[g][9]), .GateALU(outs[g][10]), .GateMARMUX(outs[g][11]),
      .PCMUX(outs[g][13:12]), .DRMUX(outs[g][14]), .SR1MUX(outs[g][15]), .SR2MUX(outs[g][16]),
      .ADDR1MUX(outs[g][17]), .ADDR2MUX(outs[g][19:18]), .MARMUX(outs[g][20]),
      .ALUK(outs[g][22:21]), .Mem_OE(outs[g][23]), .Mem_WE(outs[g][24])
    );
  end

  function automatic int mw_of(input int idx);
    return (idx == 1) ? 3 : 2;
  endfunction

  function automatic bit pe_of(input int idx);
    return (idx == 2) ? 1'b0 : 1'b1;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [24:0] w);
    q.push_back('{exp: w, cont: 1'($urandom_range(1, 0))});
  endtask

  task automatic push_c(input logic [24:0] w, input logic c);
    q.push_back('{exp: w, cont: c});
  endtask

  task automatic push_reads(input int mw);
    for (int i = 0; i < mw; i++) push(B_OE | ((i == mw - 1) ? B_LD_MDR : 25'd0));
  endtask

  task automatic push_writes(input int mw);
    for (int i = 0; i < mw; i++) push(B_WE);
  endtask

  // Expected control words, one per cycle, from FETCH to the end of the instruction.
  task automatic build(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben,
                       input int mw, input bit pe, input int k1, input int k2, input bit trail);
    logic [24:0] wb, stdata, indir, a_base, a_pc, save;
    wb     = B_GMDR | B_LD_REG | B_LD_CC;
    stdata = ALU_PASS | B_GALU | B_LD_MDR;
    indir  = B_GMDR | B_LD_MAR;
    a_base = B_GMM | B_LD_MAR | B_A1 | A2_OFF6 | B_SR1;
    a_pc   = B_GMM | B_LD_MAR | A2_OFF9;
    save   = B_DR7 | B_GPC | B_LD_REG;
    push(W_FETCH);
    push_reads(mw);
    push(B_GMDR | B_LD_IR);
    push(B_LD_BEN);
    case (op)
      4'd1:  push(B_SR1 | (ir5 ? B_SR2 : 25'd0) | B_GALU | B_LD_REG | B_LD_CC);
      4'd5:  push(ALU_AND | B_SR1 | (ir5 ? B_SR2 : 25'd0) | B_GALU | B_LD_REG | B_LD_CC);
      4'd9:  push(ALU_NOT | B_SR1 | B_GALU | B_LD_REG | B_LD_CC);
      4'd6:  begin push(a_base); push_reads(mw); push(wb); end
      4'd2:  begin push(a_pc); push_reads(mw); push(wb); end
      4'd10: begin push(a_pc); push_reads(mw); push(indir); push_reads(mw); push(wb); end
      4'd7:  begin push(a_base); push(stdata); push_writes(mw); end
      4'd3:  begin push(a_pc); push(stdata); push_writes(mw); end
      4'd11: begin push(a_pc); push_reads(mw); push(indir); push(stdata); push_writes(mw); end
      4'd14: push(A2_OFF9 | B_GMM | B_LD_REG);
      4'd4: begin
        push(save);
        push(ir11 ? (A2_OFF11 | PC_ADD | B_LD_PC) : (B_A1 | B_SR1 | PC_ADD | B_LD_PC));
      end
      4'd12: push(B_SR1 | ALU_PASS | B_GALU | PC_BUS | B_LD_PC);
      4'd0: begin
        push('0);
        if (ben) push(A2_OFF9 | PC_ADD | B_LD_PC);
      end
      4'd15: begin
        push(B_MARZ | B_GMM | B_LD_MAR);
        push(save);
        push_reads(mw);
        push(B_GMDR | PC_BUS | B_LD_PC);
      end
      4'd13: if (pe) begin
        for (int i = 0; i < k1; i++) push_c(W_LED, 1'b0);
        push_c(W_LED, 1'b1);
        for (int i = 0; i < k2; i++) push_c(W_LED, 1'b1);
        push_c(W_LED, 1'b0);
      end
      default: ;
    endcase
    if (trail) push(W_FETCH);
  endtask

  task automatic set_instr(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
    Opcode = op;
    IR_5   = ir5;
    IR_11  = ir11;
    BEN    = ben;
  endtask

  task automatic start_all();
    Reset = 1'b1;
    Run = 1'b0;
    Continue = 1'b0;
    step();
    Reset = 1'b0;
    Run = 1'b1;
    step();
    Run = 1'b0;
  endtask

  task automatic run_q(input int idx, input int reset_at, input string name);
    for (int i = 0; i < q.size(); i++) begin
      n_cmp++;
      if (outs[idx] !== q[i].exp) begin
        n_bad++;
        $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, idx, i, outs[idx], q[i].exp);
      end
      n_cmp++;
      if ($countones(outs[idx] & GATES) > 1) begin
        n_bad++;
        $display("FAIL %s_gates dut%0d cycle %0d: got %h want at most one gate", name, idx, i, outs[idx]);
      end
      Continue = q[i].cont;
      Run = 1'($urandom_range(1, 0));
      if (i == reset_at) begin
        Reset = 1'b1;
        step();
        for (int d = 0; d < 3; d++) begin
          n_cmp++;
          if (outs[d] !== W_LED) begin
            n_bad++;
            $display("FAIL %s_after_reset dut%0d: got %h want %h", name, d, outs[d], W_LED);
          end
        end
        Reset = 1'b0;
        Run = 1'b0;
        return;
      end
      step();
    end
    Run = 1'b0;
  endtask

  task automatic single(input int idx, input logic [3:0] op, input logic ir5, input logic ir11,
                        input logic ben, input int k1, input int k2, input string name);
    start_all();
    q.delete();
    set_instr(op, ir5, ir11, ben);
    build(op, ir5, ir11, ben, mw_of(idx), pe_of(idx), k1, k2, 1'b1);
    run_q(idx, -1, name);
  endtask

  task automatic count_to_fetch(input int idx, input int want, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (outs[idx] !== W_FETCH && n < 60);
    n_cmp++;
    if (n != want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d cycles want %0d", name, idx, n, want);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Run = 1'b1;
    Continue = 1'b1;
    set_instr(4'd0, 1'b0, 1'b0, 1'b0);
    step();
    Reset = 1'b0;
    Run = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (outs[d] !== W_LED) begin
          n_bad++;
          $display("FAIL reset_halted dut%0d step %0d: got %h want %h", d, r, outs[d], W_LED);
        end
      end
      step();
    end
    Run = 1'b1;
    step();
    Run = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (outs[d] !== W_FETCH) begin
        n_bad++;
        $display("FAIL run_to_fetch dut%0d: got %h want %h", d, outs[d], W_FETCH);
      end
    end
  endtask

  task automatic test_operate();
    single(0, 4'd1, 1'b1, 1'b0, 1'b0, 0, 0, "add_imm");
    single(0, 4'd5, 1'b0, 1'b0, 1'b0, 0, 0, "and_reg");
    single(0, 4'd9, 1'b0, 1'b0, 1'b0, 0, 0, "not");
    start_all();
    set_instr(4'd1, 1'b1, 1'b0, 1'b0);
    count_to_fetch(0, 6, "add_latency");
  endtask

  task automatic test_ldi_wait3();
    single(1, 4'd10, 1'b0, 1'b0, 1'b0, 0, 0, "ldi_mw3");
    start_all();
    set_instr(4'd10, 1'b0, 1'b0, 1'b0);
    count_to_fetch(1, 15, "ldi_latency");
    single(1, 4'd11, 1'b0, 1'b0, 1'b0, 0, 0, "sti_mw3");
  endtask

  task automatic test_control();
    single(0, 4'd15, 1'b0, 1'b0, 1'b0, 0, 0, "trap");
    single(0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, "br_not_taken");
    single(0, 4'd0, 1'b0, 1'b0, 1'b1, 0, 0, "br_taken");
    single(0, 4'd4, 1'b0, 1'b1, 1'b0, 0, 0, "jsr_off");
    single(0, 4'd4, 1'b0, 1'b0, 1'b0, 0, 0, "jsrr");
    single(0, 4'd12, 1'b0, 1'b0, 1'b0, 0, 0, "jmp");
    single(0, 4'd14, 1'b0, 1'b0, 1'b0, 0, 0, "lea");
  endtask

  task automatic test_reset_mid_write();
    start_all();
    q.delete();
    set_instr(4'd7, 1'b0, 1'b0, 1'b0);
    build(4'd7, 1'b0, 1'b0, 1'b0, 2, 1'b1, 0, 0, 1'b0);
    run_q(0, 8, "str_reset");
  endtask

  task automatic test_pause();
    single(0, 4'd13, 1'b0, 1'b0, 1'b0, 2, 1, "pause");
    single(0, 4'd13, 1'b0, 1'b0, 1'b0, 0, 0, "pause_short");
    single(2, 4'd13, 1'b0, 1'b0, 1'b0, 0, 0, "pause_disabled");
    single(0, 4'd8, 1'b0, 1'b0, 1'b0, 0, 0, "rti_illegal");
  endtask

  task automatic test_back_to_back(input int idx, input int count);
    logic [3:0] op;
    logic ir5, ir11, ben;
    start_all();
    for (int n = 0; n < count; n++) begin
      op   = 4'($urandom_range(15, 0));
      ir5  = 1'($urandom_range(1, 0));
      ir11 = 1'($urandom_range(1, 0));
      ben  = 1'($urandom_range(1, 0));
      q.delete();
      set_instr(op, ir5, ir11, ben);
      build(op, ir5, ir11, ben, mw_of(idx), pe_of(idx),
            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), n == count - 1);
      run_q(idx, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_operate();
    test_ldi_wait3();
    test_control();
    test_reset_mid_write();
    test_pause();
    test_back_to_back(0, 150);
    test_back_to_back(1, 50);
    test_back_to_back(2, 50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
